alu_mc: RTL and testbench

Parametrised multi-cycle ALU for the audio core datapath: generalises the single-cycle ALU to WIDTH bits, adds iterative multiply/divide, signed compare and saturating audio arithmetic, behind a valid/ready handshake. Single-cycle ops complete in one cycle; MUL/DIVU/REMU run an iterative engine so no wide combinational multiplier or divider is needed. Results are registered and held until the consumer accepts them.

---
 rtl/alu_mc_if.sv | 26 ++
 rtl/alu_mc.sv | 193 +++++++++++++++++++
 tb/tb_alu_mc.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/alu_mc_if.sv
// Operand/result handshake bundle for alu_mc.
// The master drives operands and out_ready; the slave (the ALU) returns the result.
interface alu_mc_if #(
   parameter int unsigned WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       alu_ctrl;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             sat;

   modport master (
      output in_valid, a, b, alu_ctrl, out_ready,
      input  in_ready, out_valid, result, zero, sat
   );

   modport slave (
      input  in_valid, a, b, alu_ctrl, out_ready,
      output in_ready, out_valid, result, zero, sat
   );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/saturating ops, plus iterative
// shift-add multiply and restoring divide, behind a valid/ready handshake.
module alu_mc #(
   parameter int unsigned WIDTH = 32
) (
   input  logic     clk,
   input  logic     rst,
   alu_mc_if.slave  bus
);
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_SLTU = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_MUL  = 4'b1000;
   localparam logic [3:0] OP_DIVU = 4'b1001;
   localparam logic [3:0] OP_REMU = 4'b1010;
   localparam logic [3:0] OP_SADD = 4'b1011;
   localparam logic [3:0] OP_SSUB = 4'b1100;

   localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [3:0]       op_q, op_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             sat_q, sat_d;
   logic             in_ready_q;
   logic             out_valid_q;

   // Single-cycle result computed straight from the presented operands.
   logic [WIDTH-1:0] sc_res;
   logic             sc_sat;
   logic             sc_iter;
   logic [WIDTH-1:0] sum, diff;

   always_comb begin
      sc_res  = '0;
      sc_sat  = 1'b0;
      sc_iter = 1'b0;
      sum     = bus.a + bus.b;
      diff    = bus.a - bus.b;
      case (bus.alu_ctrl)
         OP_AND:  sc_res = bus.a & bus.b;
         OP_OR:   sc_res = bus.a | bus.b;
         OP_ADD:  sc_res = sum;
         OP_XOR:  sc_res = bus.a ^ bus.b;
         OP_SUB:  sc_res = diff;
         OP_SLT:  sc_res = WIDTH'($signed(bus.a) < $signed(bus.b));
         OP_SLTU: sc_res = WIDTH'(bus.a < bus.b);
         OP_MUL:  sc_iter = 1'b1;
         OP_DIVU: begin
            sc_iter = (bus.b != '0);
            sc_res  = '1;
         end
         OP_REMU: begin
            sc_iter = (bus.b != '0);
            sc_res  = bus.a;
         end
         OP_SADD: begin
            sc_sat = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            sc_res = sc_sat ? (bus.a[WIDTH-1] ? SMIN : SMAX) : sum;
         end
         OP_SSUB: begin
            sc_sat = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
            sc_res = sc_sat ? (bus.a[WIDTH-1] ? SMIN : SMAX) : diff;
         end
         default: sc_res = '0;
      endcase
   end

   // One iteration step: a_q is multiplicand / dividend-quotient shifter,
   // b_q is multiplier / divisor, acc_q is product / partial remainder.
   logic [WIDTH-1:0] mul_acc;
   logic [WIDTH:0]   rem_sh, rem_sub;
   logic             div_ge;
   logic [WIDTH-1:0] rem_nx, quo_nx;

   always_comb begin
      mul_acc = acc_q + (b_q[0] ? a_q : '0);
      rem_sh  = {acc_q, a_q[WIDTH-1]};
      div_ge  = (rem_sh >= {1'b0, b_q});
      rem_sub = rem_sh - {1'b0, b_q};
      rem_nx  = div_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      quo_nx  = {a_q[WIDTH-2:0], div_ge};
   end

   logic             wr_en;
   logic [WIDTH-1:0] wr_val;

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      zero_d   = zero_q;
      sat_d    = sat_q;
      wr_en    = 1'b0;
      wr_val   = '0;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_d   = bus.a;
               b_d   = bus.b;
               op_d  = bus.alu_ctrl;
               acc_d = '0;
               sat_d = sc_sat;
               if (sc_iter) begin
                  cnt_d   = CNT_W'(WIDTH);
                  state_d = BUSY;
               end else begin
                  wr_en   = 1'b1;
                  wr_val  = sc_res;
                  state_d = DONE;
               end
            end
         end
         BUSY: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (op_q == OP_MUL) begin
               acc_d = mul_acc;
               a_d   = a_q << 1;
               b_d   = b_q >> 1;
            end else begin
               acc_d = rem_nx;
               a_d   = quo_nx;
            end
            if (cnt_q == CNT_W'(1)) begin
               wr_en   = 1'b1;
               wr_val  = (op_q == OP_MUL)  ? mul_acc :
                         (op_q == OP_DIVU) ? quo_nx  : rem_nx;
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (wr_en) begin
         result_d = wr_val;
         zero_d   = (wr_val == '0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         sat_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         sat_q       <= sat_d;
         in_ready_q  <= (state_d == IDLE);
         out_valid_q <= (state_d == DONE);
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.zero      = zero_q;
   assign bus.sat       = sat_q;
endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc at WIDTH=32: latency, results, flags,
// divide-by-zero, reset abort and backpressure.
module tb_alu_mc;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   alu_mc_if #(.WIDTH(32)) bus ();
   alu_mc #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present an op at a negedge; returns after the accept edge with in_valid dropped.
   task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
      bus.alu_ctrl = op;
      bus.a        = a;
      bus.b        = b;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.out_valid && lat < 100);
   endtask

   task automatic finish_hs();
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("out_valid_after_hs", 32'(bus.out_valid), 32'd0);
      check("in_ready_after_hs", 32'(bus.in_ready), 32'd1);
   endtask

   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input logic exp_zero, input logic exp_sat, input int exp_lat);
      int lat;
      start_op(op, a, b);
      wait_valid(lat);
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_res"}, bus.result, exp_res);
      check({tag, "_zero"}, 32'(bus.zero), 32'(exp_zero));
      check({tag, "_sat"}, 32'(bus.sat), 32'(exp_sat));
      check({tag, "_in_ready_low"}, 32'(bus.in_ready), 32'd0);
      finish_hs();
   endtask

   initial begin
      int lat;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.alu_ctrl  = '0;
      bus.out_ready = 1'b0;

      // Reset state while reset is held
      repeat (3) @(negedge clk);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_result", bus.result, 32'd0);
      check("rst_zero", 32'(bus.zero), 32'd0);
      check("rst_sat", 32'(bus.sat), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("in_ready_out_of_reset", 32'(bus.in_ready), 32'd1);

      // Reset mid-MUL discards the operation
      start_op(4'b1000, 32'd7, 32'd9);
      repeat (5) @(negedge clk);
      check("mul_busy_no_valid", 32'(bus.out_valid), 32'd0);
      rst = 1'b1;
      #1;
      check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      check("midrst_result", bus.result, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (40) begin
         @(negedge clk);
         check("post_rst_no_valid", 32'(bus.out_valid), 32'd0);
      end
      run_op("add_after_rst", 4'b0010, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1);

      // Single-cycle ops
      run_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1);
      run_op("slt", 4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1);
      run_op("sltu", 4'b0101, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1);
      run_op("sub_wrap", 4'b0110, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b0, 1);
      run_op("and", 4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1'b0, 1);
      run_op("xor", 4'b0011, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0, 1'b0, 1);
      run_op("bad_op", 4'b1111, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0, 1);

      // Saturating arithmetic
      run_op("sadd_pos", 4'b1011, 32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1);
      run_op("ssub_neg", 4'b1100, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0, 1'b1, 1);
      run_op("sadd_ok", 4'b1011, 32'd5, 32'd3, 32'd8, 1'b0, 1'b0, 1);

      // Iterative ops
      run_op("mul_zero", 4'b1000, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1, 1'b0, 33);
      run_op("mul_7x9", 4'b1000, 32'd7, 32'd9, 32'd63, 1'b0, 1'b0, 33);
      run_op("divu", 4'b1001, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 33);
      run_op("remu", 4'b1010, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0, 33);
      run_op("divu_big", 4'b1001, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 1'b0, 1'b0, 33);

      // Divide by zero short-circuit
      run_op("divu_by0", 4'b1001, 32'd42, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1);
      run_op("remu_by0", 4'b1010, 32'd42, 32'd0, 32'd42, 1'b0, 1'b0, 1);

      // Backpressure: result held, new requests ignored
      start_op(4'b1000, 32'd3, 32'd5);
      wait_valid(lat);
      check("bp_lat", 32'(lat), 32'd33);
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = i[0];
         bus.alu_ctrl = 4'b0010;
         bus.a        = 32'd1;
         bus.b        = 32'd1;
         @(negedge clk);
         check("bp_result_held", bus.result, 32'd15);
         check("bp_out_valid_held", 32'(bus.out_valid), 32'd1);
         check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid = 1'b0;
      finish_hs();
      run_op("after_bp", 4'b0001, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1'b0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
